// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state encoding,
// ALU operation codes and the instruction classes the decoder produces.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_LDI  = 3'd2,
        CLS_ST   = 3'd3,
        CLS_ALU  = 3'd4,
        CLS_ADDI = 3'd5,
        CLS_HALT = 3'd6
    } cls_t;

endpackage

// File: rtl/opcode_decode.sv
// Maps a 5-bit opcode to its instruction class and ALU operation.
// Unknown opcodes fall into the nop class.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls,
    output alu_op_t    alu
);

    always_comb begin
        cls = CLS_NOP;
        alu = ALU_ADD;
        case (opcode)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD:  cls = CLS_ALU;
            OP_SUB:  begin cls = CLS_ALU; alu = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU; alu = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU; alu = ALU_OR;  end
            OP_ADDI: cls = CLS_ADDI;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch T0-T2, execute T3-T7, terminal HALT.
// Opcode is captured leaving T2; execute states decode only the captured copy.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MD_read,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Csignout,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        halted
);

    state_t     state, state_next;
    logic [4:0] opcode_q;
    logic [4:0] dec_in;
    cls_t       cls;
    alu_op_t    dec_alu;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];

    // In T2 the route (nop/halt/execute) must come from the live IR since the
    // latch has not happened yet; everywhere else the latched opcode is used.
    assign dec_in = (state == S_T2) ? ir[31:27] : opcode_q;

    opcode_decode u_dec (
        .opcode (dec_in),
        .cls    (cls),
        .alu    (dec_alu)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_RESET;
            opcode_q <= 5'd0;
        end else begin
            state <= state_next;
            if (state == S_T2) opcode_q <= ir[31:27];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    if (mem_ready) state_next = S_T2;
            S_T2: begin
                if (cls == CLS_HALT)     state_next = S_HALT;
                else if (cls == CLS_NOP) state_next = S_T0;
                else                     state_next = S_T3;
            end
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = (cls == CLS_LD || cls == CLS_ST) ? S_T6 : S_T0;
            S_T6: begin
                if (cls == CLS_ST || mem_ready) state_next = S_T7;
            end
            S_T7: begin
                if (cls == CLS_LD || mem_ready) state_next = S_T0;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; MD_read = 1'b0; Read = 1'b0;
        Write = 1'b0; IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0;
        Zhighin = 1'b0; Zlowout = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Csignout = 1'b0; alu_op = 4'b0000;
        run    = (state != S_RESET) && (state != S_HALT);
        halted = (state == S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                Grb = 1'b1; Yin = 1'b1;
                if (cls == CLS_ALU || cls == CLS_ADDI) Rout = 1'b1;
                else                                   BAout = 1'b1;
            end
            S_T4: begin
                Zlowin = 1'b1;
                alu_op = dec_alu;
                if (cls == CLS_ALU) begin Grc = 1'b1; Rout = 1'b1; end
                else                Csignout = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) MARin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (cls == CLS_ST) begin Gra = 1'b1; Rout = 1'b1; end
                else begin Read = 1'b1; MD_read = 1'b1; end
            end
            S_T7: begin
                if (cls == CLS_ST) Write = 1'b1;
                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule
